opsum_glb_write_arbiter: RTL
============================

# opsum_glb_write_arbiter

Arbitrates GLB write access among the per-channel opsum FIFO controllers in the token engine and drives the single GLB write port. Each controller raises a write request while it has data to drain. The arbiter returns a one-hot pop permit, latches the granted channel's address, byte-enable and data, and issues the GLB write one cycle later. Grants are round-robin with a bounded burst lock, so one channel drains several words back-to-back without starving the others.

## Interface
Parameters:
- NUM_CH, 4: number of opsum FIFO controller channels (≥2).
- ADDR_W, 32: GLB address width.
- DATA_W, 32: GLB data width; byte enables are DATA_W/8 wide.
- BURST_MAX, 4: maximum consecutive grants to one channel before rotation (≥1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- ch_write_req_i  in  NUM_CH  per-channel write request.
- ch_glb_write_addr_i  in  NUM_CH×ADDR_W  per-channel write address.
- ch_glb_write_web_i  in  NUM_CH×(DATA_W/8)  per-channel byte enables (1 = write byte).
- ch_glb_write_data_i  in  NUM_CH×DATA_W  per-channel write data.
- glb_busy_i  in  1  GLB port owned by another master; no grant is issued while high.
- ch_permit_pop_o  out  NUM_CH  one-hot (or zero) pop permit, combinational.
- glb_we_o  out  1  GLB write strobe, registered.
- glb_addr_o  out  ADDR_W  GLB write address, registered.
- glb_web_o  out  DATA_W/8  GLB byte enables, registered.
- glb_wdata_o  out  DATA_W  GLB write data, registered.
- grant_id_o  out  $clog2(NUM_CH)  index of the last granted channel, registered.
- arb_busy_o  out  1  a grant issued this cycle, or a write is pending on the port.

## Operation
- State machine `arb_state_t`:
  - ARB_IDLE: no lock held.
  - ARB_LOCK: a channel `lock_id` is locked and burst counter `burst_cnt` is active.
- In ARB_IDLE with glb_busy_i=0 and any request:
  - Grant the first requester at or after `rr_ptr`, searching with wrap-around modulo NUM_CH.
  - Load `lock_id`, set burst_cnt=1, go to ARB_LOCK.
- In ARB_LOCK:
  - If ch_write_req_i[lock_id]=1, glb_busy_i=0 and burst_cnt<BURST_MAX: grant lock_id again and increment burst_cnt.
  - Release the lock when the request drops, or when burst_cnt==BURST_MAX. On release, set rr_ptr=lock_id+1 (wrapping) and go to ARB_IDLE.
  - The release cycle issues no grant. Re-arbitration happens the following cycle.
- glb_busy_i=1: all permits are 0. Lock and burst_cnt are held, not released.
- Any cycle with a grant to channel k captures ch_*_i[k] into the output registers.
- burst_cnt is $clog2(BURST_MAX+1) bits wide and never exceeds BURST_MAX.

## Timing
- ch_permit_pop_o is combinational from the current state, ch_write_req_i and glb_busy_i. It is asserted in the same cycle as the pop.
- Permit at cycle T produces glb_we_o=1 at T+1 with the channel-k addr/web/data sampled at T. Latency is 1. Throughput is 1 write per cycle.
- glb_we_o deasserts the cycle after a cycle with no grant. Address, data and web hold their last value.
- Reset values: state ARB_IDLE, rr_ptr=0, burst_cnt=0, all outputs 0.
- rst asserted mid-burst: state, pointers and outputs clear on that edge. A write staged but not yet issued is dropped. Controllers must also be reset.
- A request dropping in the same cycle as the lock's BURST_MAX-th grant: one release, no double rotation.

## Configuration
- `OPSUM_ARB_BURST_LOCK_EN` defined: burst lock as described above.
- Not defined:
  - ARB_LOCK is never entered.
  - Every grant advances rr_ptr to granted+1, giving single-beat round-robin.
  - BURST_MAX is ignored.
  - Grants may be issued every cycle with no release bubble.

## Structure
- Shared package `token_engine_pkg` holds:
  - `arb_state_t`
  - default BURST_MAX
  - GLB byte-enable constants WEB_LO16=4'b0011, WEB_HI16=4'b1100, WEB_ALL=4'b1111.
- One sub-module, `rr_pick`: a combinational rotating priority picker taking (req vector, rr_ptr) and returning (valid, index).

## Test plan
- Single channel: ch 2 requests 6 cycles, BURST_MAX=4 → permits at T..T+3, bubble at T+4, permits at T+5..T+6. glb_we_o follows one cycle later with ch 2 addresses.
- Fairness: all 4 channels request continuously → burst order 0,1,2,3,0, each 4 beats, with 1 bubble between bursts.
- Busy stall: glb_busy_i high for 3 cycles mid-burst → permits 0, burst_cnt frozen; the burst resumes with its remaining beats.
- Byte enables: ch 1 presents addr 0x102, web 4'b1100, data 0xABCD0000 → glb_* equal these values exactly at T+1.
- Mid-burst reset: rst at the 2nd beat → next cycle all outputs 0, rr_ptr=0; a new request on ch 3 is granted first.
- Macro off: channels 0 and 1 both request → permits alternate 0,1,0,1 every cycle with no bubbles.

Source files
------------

// File: rtl/token_engine_pkg.sv
// Shared token-engine types and GLB write constants.
package token_engine_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned BURST_MAX_DEFAULT = 4;

  localparam logic [3:0] WEB_LO16 = 4'b0011;
  localparam logic [3:0] WEB_HI16 = 4'b1100;
  localparam logic [3:0] WEB_ALL  = 4'b1111;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or after ptr_i, wrapping modulo NUM_CH.
module rr_pick #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o
);

  always_comb begin : pick
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/opsum_glb_write_arbiter.sv
// Round-robin GLB write arbiter for the opsum FIFO controllers.
// Define OPSUM_ARB_BURST_LOCK_EN for bounded burst locking; otherwise single-beat round-robin.
module opsum_glb_write_arbiter
  import token_engine_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_write_req_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_glb_write_addr_i,
  input  logic [NUM_CH*(DATA_W/8)-1:0] ch_glb_write_web_i,
  input  logic [NUM_CH*DATA_W-1:0]     ch_glb_write_data_i,
  input  logic                         glb_busy_i,
  output logic [NUM_CH-1:0]            ch_permit_pop_o,
  output logic                         glb_we_o,
  output logic [ADDR_W-1:0]            glb_addr_o,
  output logic [DATA_W/8-1:0]          glb_web_o,
  output logic [DATA_W-1:0]            glb_wdata_o,
  output logic [$clog2(NUM_CH)-1:0]    grant_id_o,
  output logic                         arb_busy_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned WEB_W = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
`ifdef OPSUM_ARB_BURST_LOCK_EN
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
`endif

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  logic [ADDR_W-1:0] sel_addr;
  logic [WEB_W-1:0]  sel_web;
  logic [DATA_W-1:0] sel_data;

  logic              glb_we_q;
  logic [ADDR_W-1:0] glb_addr_q;
  logic [WEB_W-1:0]  glb_web_q;
  logic [DATA_W-1:0] glb_wdata_q;
  logic [IDX_W-1:0]  grant_id_q;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_CH) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req_i   (ch_write_req_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_valid = 1'b0;
    grant_idx   = pick_idx;
`ifdef OPSUM_ARB_BURST_LOCK_EN
    unique case (state_q)
      ARB_IDLE: begin
        if (!glb_busy_i && pick_valid) begin
          grant_valid = 1'b1;
          lock_id_d   = pick_idx;
          burst_cnt_d = CNT_W'(1);
          state_d     = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        // Busy freezes the lock; release only happens on a free port cycle and issues no grant.
        if (!glb_busy_i) begin
          if (ch_write_req_i[lock_id_q] && (burst_cnt_q < BURST_LIM)) begin
            grant_valid = 1'b1;
            grant_idx   = lock_id_q;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            rr_ptr_d    = wrap_inc(lock_id_q);
            burst_cnt_d = '0;
            state_d     = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
`else
    if (!glb_busy_i && pick_valid) begin
      grant_valid = 1'b1;
      rr_ptr_d    = wrap_inc(pick_idx);
    end
`endif
  end

  always_comb begin
    sel_addr        = '0;
    sel_web         = '0;
    sel_data        = '0;
    ch_permit_pop_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_addr = ch_glb_write_addr_i[k*ADDR_W +: ADDR_W];
        sel_web  = ch_glb_write_web_i[k*WEB_W +: WEB_W];
        sel_data = ch_glb_write_data_i[k*DATA_W +: DATA_W];
        ch_permit_pop_o[k] = grant_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      glb_we_q    <= 1'b0;
      glb_addr_q  <= '0;
      glb_web_q   <= '0;
      glb_wdata_q <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      glb_we_q    <= grant_valid;
      if (grant_valid) begin
        glb_addr_q  <= sel_addr;
        glb_web_q   <= sel_web;
        glb_wdata_q <= sel_data;
        grant_id_q  <= grant_idx;
      end
    end
  end

  assign glb_we_o    = glb_we_q;
  assign glb_addr_o  = glb_addr_q;
  assign glb_web_o   = glb_web_q;
  assign glb_wdata_o = glb_wdata_q;
  assign grant_id_o  = grant_id_q;
  assign arb_busy_o  = grant_valid | glb_we_q;

endmodule
